// File: rtl/layer_output_streamer_if.sv
// Output stream bundle of the layer output streamer: one signed word per
// handshake together with its position in the frame.
interface layer_output_streamer_if #(
    parameter int DWIDTH = 16,
    parameter int N      = 10
);
    localparam int IW = $clog2(N);

    logic signed [DWIDTH-1:0] out_data;
    logic [IW-1:0]            out_index;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/layer_output_streamer.sv
// Captures one layer's N parallel neuron outputs and streams them one word
// per handshake, reporting the signed argmax of each completed frame.
//
// state  | meaning
// IDLE   | bank holds last frame, ready to capture a new one
// STREAM | presenting bank[idx], advancing on each handshake
module layer_output_streamer #(
    parameter int  DWIDTH = 16,
    parameter int  N      = 10,
    localparam int IW     = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [N*DWIDTH-1:0]      data_in,
    output logic                     load_ready,
    output logic                     done,
    output logic [IW-1:0]            max_index,
    output logic signed [DWIDTH-1:0] max_value,
    layer_output_streamer_if.master  strm
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t                   state;
    logic signed [DWIDTH-1:0] bank [N];
    logic [IW-1:0]            idx;
    logic signed [DWIDTH-1:0] run_max;
    logic [IW-1:0]            run_idx;
    logic signed [DWIDTH-1:0] word;
    logic                     take_new;

    // Current word and whether it becomes the running max; word 0 always
    // seeds the tracker, later words must be strictly greater so ties keep
    // the lowest index.
    always_comb begin
        word     = bank[idx];
        take_new = (idx == '0) || (word > run_max);
    end

    assign load_ready     = (state == IDLE);
    assign strm.out_valid = (state == STREAM);
    assign strm.out_data  = word;
    assign strm.out_index = idx;
    assign strm.out_last  = (state == STREAM) && (idx == LAST);

    // Frame capture, stream sequencing and max tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            max_index <= '0;
            max_value <= '0;
            done      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                bank[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int k = 0; k < N; k++) begin
                            bank[k] <= data_in[k*DWIDTH +: DWIDTH];
                        end
                        idx   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (strm.out_ready) begin
                        if (take_new) begin
                            run_max <= word;
                            run_idx <= idx;
                        end
                        if (idx == LAST) begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            max_value <= take_new ? word : run_max;
                            max_index <= take_new ? idx : run_idx;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_output_streamer.sv
// Directed bench for layer_output_streamer: inputs driven and outputs
// sampled on the falling edge, expected values written out by hand.
module tb_layer_output_streamer;
    localparam int DW = 16;
    localparam int N  = 10;
    localparam int IW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 load = 1'b0;
    logic                 out_ready = 1'b1;
    logic [N*DW-1:0]      data_in = '0;
    logic                 load_ready;
    logic                 done;
    logic [IW-1:0]        max_index;
    logic signed [DW-1:0] max_value;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] w [N];

    layer_output_streamer_if #(.DWIDTH(DW), .N(N)) strm_if ();
    assign strm_if.out_ready = out_ready;

    layer_output_streamer #(.DWIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .load_ready (load_ready),
        .done       (done),
        .max_index  (max_index),
        .max_value  (max_value),
        .strm       (strm_if)
    );

    always #5 clk = ~clk;

    task automatic pack_w();
        for (int k = 0; k < N; k++) data_in[k*DW +: DW] = w[k];
    endtask

    // Leaves the bench at the falling edge where word 0 is presented.
    task automatic start_frame();
        @(negedge clk);
        pack_w();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) w[k] = DW'(k + 11);
        start_frame();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %0b exp 1", load_ready); end
        checks++; if (strm_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", strm_if.out_valid); end
        checks++; if (strm_if.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %0b exp 0", strm_if.out_last); end
        checks++; if (strm_if.out_data !== 16'sd0) begin errors++; $display("FAIL rst_out_data got %0d exp 0", strm_if.out_data); end
        checks++; if (strm_if.out_index !== 4'd0) begin errors++; $display("FAIL rst_out_index got %0d exp 0", strm_if.out_index); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (max_index !== 4'd0 || max_value !== 16'sd0) begin errors++; $display("FAIL rst_max got %0d/%0d exp 0/0", max_index, max_value); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        for (int k = 0; k < N; k++) w[k] = DW'(k * 100);
        start_frame();
        for (int k = 0; k < N; k++) begin
            checks++; if (strm_if.out_valid !== 1'b1 || strm_if.out_index !== IW'(k)) begin errors++; $display("FAIL basic_valid_idx k=%0d got %0b/%0d exp 1/%0d", k, strm_if.out_valid, strm_if.out_index, k); end
            checks++; if (strm_if.out_data !== w[k]) begin errors++; $display("FAIL basic_data k=%0d got %0d exp %0d", k, strm_if.out_data, w[k]); end
            checks++; if (strm_if.out_last !== (k == N - 1)) begin errors++; $display("FAIL basic_last k=%0d got %0b exp %0b", k, strm_if.out_last, k == N - 1); end
            checks++; if (done !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL basic_busy k=%0d done %0b load_ready %0b exp 0/0", k, done, load_ready); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || load_ready !== 1'b1 || strm_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_end done %0b load_ready %0b valid %0b exp 1/1/0", done, load_ready, strm_if.out_valid); end
        checks++; if (max_index !== 4'd9 || max_value !== 16'sd900) begin errors++; $display("FAIL basic_max got %0d/%0d exp 9/900", max_index, max_value); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
    endtask

    task automatic test_signed_backpressure(input logic signed [DW-1:0] v4,
                                            input logic [IW-1:0] exp_mi,
                                            input logic signed [DW-1:0] exp_mv);
        int e;
        int cyc;
        w[0] = -16'sd5; w[1] = 16'sd3; w[2] = -16'sd32768; w[3] = 16'sd3; w[4] = v4;
        for (int k = 5; k < N; k++) w[k] = 16'sd0;
        start_frame();
        e = 0;
        cyc = 0;
        while (e < N && cyc < 40) begin
            checks++; if (strm_if.out_valid !== 1'b1 || strm_if.out_index !== IW'(e) || strm_if.out_data !== w[e]) begin errors++; $display("FAIL bp_word cyc=%0d got %0b/%0d/%0d exp 1/%0d/%0d", cyc, strm_if.out_valid, strm_if.out_index, strm_if.out_data, e, w[e]); end
            checks++; if (strm_if.out_last !== (e == N - 1) || done !== 1'b0) begin errors++; $display("FAIL bp_flags cyc=%0d last %0b done %0b exp %0b/0", cyc, strm_if.out_last, done, e == N - 1); end
            out_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (out_ready) e++;
            cyc++;
        end
        checks++; if (e != N) begin errors++; $display("FAIL bp_timeout delivered %0d exp %0d", e, N); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %0b exp 1", done); end
        checks++; if (max_index !== exp_mi || max_value !== exp_mv) begin errors++; $display("FAIL bp_max got %0d/%0d exp %0d/%0d", max_index, max_value, exp_mi, exp_mv); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // Ends on the falling edge where done is visible, still in IDLE.
    task automatic test_load_collision();
        for (int k = 0; k < N; k++) w[k] = DW'(k * 100);
        start_frame();
        for (int k = 0; k < N; k++) begin
            checks++; if (strm_if.out_index !== IW'(k) || strm_if.out_data !== w[k]) begin errors++; $display("FAIL coll_word k=%0d got %0d/%0d exp %0d/%0d", k, strm_if.out_index, strm_if.out_data, k, w[k]); end
            if (k == 3) begin
                for (int j = 0; j < N; j++) data_in[j*DW +: DW] = DW'(-1000 - j);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || max_index !== 4'd9 || max_value !== 16'sd900) begin errors++; $display("FAIL coll_end done %0b max %0d/%0d exp 1 9/900", done, max_index, max_value); end
    endtask

    task automatic test_back_to_back();
        int ph;
        for (int k = 0; k < N; k++) w[k] = DW'(k * 7 - 20);
        pack_w();
        load = 1'b1;
        for (int cyc = 0; cyc < 2 * (N + 1); cyc++) begin
            @(negedge clk);
            ph = cyc % (N + 1);
            if (ph < N) begin
                checks++; if (strm_if.out_valid !== 1'b1 || load_ready !== 1'b0 || strm_if.out_index !== IW'(ph) || strm_if.out_data !== w[ph]) begin errors++; $display("FAIL b2b_word cyc=%0d got %0b/%0b/%0d/%0d exp 1/0/%0d/%0d", cyc, strm_if.out_valid, load_ready, strm_if.out_index, strm_if.out_data, ph, w[ph]); end
            end else begin
                checks++; if (strm_if.out_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL b2b_gap cyc=%0d valid %0b load_ready %0b done %0b exp 0/1/1", cyc, strm_if.out_valid, load_ready, done); end
                checks++; if (max_index !== 4'd9 || max_value !== 16'sd43) begin errors++; $display("FAIL b2b_max got %0d/%0d exp 9/43", max_index, max_value); end
            end
        end
        load = 1'b0;
        @(negedge clk);
        checks++; if (strm_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_stop got %0b exp 0", strm_if.out_valid); end
    endtask

    task automatic test_result_hold();
        for (int k = 0; k < N; k++) w[k] = DW'(k * 100);
        start_frame();
        for (int k = 0; k < N; k++) @(negedge clk);
        checks++; if (done !== 1'b1 || max_index !== 4'd9 || max_value !== 16'sd900) begin errors++; $display("FAIL hold_a done %0b max %0d/%0d exp 1 9/900", done, max_index, max_value); end
        for (int k = 0; k < N; k++) w[k] = DW'(500 - k * 10);
        start_frame();
        for (int k = 0; k < N; k++) begin
            if (k < 5) begin
                checks++; if (max_index !== 4'd9 || max_value !== 16'sd900) begin errors++; $display("FAIL hold_mid k=%0d got %0d/%0d exp 9/900", k, max_index, max_value); end
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || max_index !== 4'd0 || max_value !== 16'sd500) begin errors++; $display("FAIL hold_b done %0b max %0d/%0d exp 1 0/500", done, max_index, max_value); end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < N; k++) w[k] = DW'(k * 3 + 1);
        start_frame();
        for (int k = 0; k < 4; k++) @(negedge clk);
        checks++; if (strm_if.out_index !== 4'd4 || strm_if.out_data !== 16'sd13) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 4/13", strm_if.out_index, strm_if.out_data); end
        #2 reset = 1'b0;
        #1;
        checks++; if (strm_if.out_valid !== 1'b0 || load_ready !== 1'b1 || strm_if.out_index !== 4'd0) begin errors++; $display("FAIL mid_async valid %0b load_ready %0b idx %0d exp 0/1/0", strm_if.out_valid, load_ready, strm_if.out_index); end
        checks++; if (max_index !== 4'd0 || max_value !== 16'sd0) begin errors++; $display("FAIL mid_max got %0d/%0d exp 0/0", max_index, max_value); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || strm_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_nodone c=%0d done %0b valid %0b exp 0/0", c, done, strm_if.out_valid); end
        end
        for (int k = 0; k < N; k++) w[k] = DW'(k - 5);
        start_frame();
        checks++; if (strm_if.out_valid !== 1'b1 || strm_if.out_index !== 4'd0 || strm_if.out_data !== -16'sd5) begin errors++; $display("FAIL mid_restart got %0b/%0d/%0d exp 1/0/-5", strm_if.out_valid, strm_if.out_index, strm_if.out_data); end
        for (int k = 0; k < N; k++) @(negedge clk);
        checks++; if (done !== 1'b1 || max_index !== 4'd9 || max_value !== 16'sd4) begin errors++; $display("FAIL mid_final done %0b max %0d/%0d exp 1 9/4", done, max_index, max_value); end
    endtask

    initial begin
        #12 reset = 1'b1;
        test_reset();
        test_basic();
        test_signed_backpressure(16'sd32767, 4'd4, 16'sd32767);
        test_signed_backpressure(16'sd2, 4'd1, 16'sd3);
        test_load_collision();
        test_back_to_back();
        test_result_hold();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
